// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-path widths, reset PC and queue entry type
package cpu_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry prefetch FIFO of fetch entries with flush
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_push_entry,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [CNT_W-1:0]   o_count,
  output fetch_entry_t       o_head
);

  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_mem [DEPTH];

  // Storage and pointers; a flush empties the queue and wins over a push,
  // while a same-cycle pop has already been consumed by the reader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, credit-based imem request issue and redirect flush
module instr_fetch_unit #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int DEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;

  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_used;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_entry;
  logic              w_kill;
  logic              w_push;
  logic              w_pop;
  logic              w_req;

  // A redirect kills the read returning this cycle; its data never enters the queue.
  assign w_kill = redirect_valid;
  assign w_push = r_inflight && !w_kill;
  assign w_pop  = if_valid && id_ready;

  // Slots committed after this edge: entries staying in the queue plus the
  // returning read. Counting the pop lets DEPTH=2 stream one word per cycle.
  assign w_used = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);
  assign w_req  = reset && !redirect_valid && (w_used < (CNT_W+1)'(DEPTH));

  assign imem_req     = w_req;
  assign imem_addr    = r_fetch_pc;
  assign if_valid     = (w_count != '0);
  assign if_instr     = w_head.instr;
  assign if_pc        = w_head.pc;
  assign w_push_entry = '{instr: imem_rdata, pc: r_inflight_pc};

  // Fetch PC sequencing and tracking of the single outstanding read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_req;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(PC_STEP);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_fetch_queue (
    .clk          (clk),
    .rst_n        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_count      (w_count),
    .o_head       (w_head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] imem_rdata2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [31:0] if_pc2;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_out[$];
  logic [31:0] exp_req[$];
  logic [31:0] got2[$];
  logic        s_valid;
  logic        s_req;
  logic [31:0] s_pc;
  logic [31:0] s_pc2;
  int          reqs;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  instr_fetch_unit #(
    .RESET_PC(32'hFFFF_FFF8)
  ) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req2),
    .imem_addr      (imem_addr2),
    .imem_rdata     (imem_rdata2),
    .if_valid       (if_valid2),
    .if_instr       (if_instr2),
    .if_pc          (if_pc2),
    .id_ready       (1'b1),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
  );

  // Instruction memory: word at byte address A holds A>>2, one-cycle latency.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? (imem_addr  >> 2) : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_req2 ? (imem_addr2 >> 2) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    s_valid = if_valid;
    s_req   = imem_req;
    s_pc    = if_pc;
    s_pc2   = if_pc2;
    if (imem_req && exp_req.size() > 0) begin
      e = exp_req.pop_front();
      check("req_addr", imem_addr, e);
    end
    if (imem_req2) got2.push_back(imem_addr2);
    if (if_valid && id_ready) begin
      n_tests++;
      assert (exp_out.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_out observed pc=%h expected none", if_pc);
      end
      if (exp_out.size() > 0) begin
        e = exp_out.pop_front();
        check("out_pc", if_pc, e);
        check("out_instr", if_instr, e >> 2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string tag);
    check({tag, "_out_left"}, 32'(exp_out.size()), 32'd0);
    check({tag, "_req_left"}, 32'(exp_req.size()), 32'd0);
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    cyc();
    cyc();
    exp_out.delete();
    exp_req.delete();
    got2.delete();
  endtask

  initial begin
    reset          = 1'b0;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    cyc();
    cyc();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);

    // Streaming from cold start, plus wrap-around on the second instance
    id_ready = 1'b1;
    for (int a = 0; a < 8; a++) exp_req.push_back(32'(a * 4));
    for (int a = 0; a < 6; a++) exp_out.push_back(32'(a * 4));
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("t1_valid", 32'(s_valid), 32'(i >= 2));
      if (i == 2) check("wrap_pc0", s_pc2, 32'hFFFF_FFF8);
      if (i == 3) check("wrap_pc1", s_pc2, 32'hFFFF_FFFC);
      if (i == 4) check("wrap_pc2", s_pc2, 32'h0000_0000);
    end
    check("wrap_nreq", 32'(got2.size() >= 3), 32'd1);
    if (got2.size() >= 3) begin
      check("wrap_addr0", got2[0], 32'hFFFF_FFF8);
      check("wrap_addr1", got2[1], 32'hFFFF_FFFC);
      check("wrap_addr2", got2[2], 32'h0000_0000);
    end
    drained("t1");

    // Backpressure from cold start: exactly DEPTH requests, head held
    id_ready = 1'b0;
    hold_reset();
    foreach (exp_req[i]) exp_req.delete(i);
    for (int a = 0; a < 5; a++) exp_req.push_back(32'(a * 4));
    for (int a = 0; a < 3; a++) exp_out.push_back(32'(a * 4));
    reqs = 0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (s_req) reqs++;
      if (i >= 2) check("t2_hold_pc", s_pc, 32'h0);
    end
    check("t2_nreq", 32'(reqs), 32'd2);
    check("t2_valid", 32'(s_valid), 32'd1);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t2_no_gap", 32'(s_valid), 32'd1);
    end
    drained("t2");

    // Redirect to 0x40 while 0x0C returns and 0x08 sits in the queue
    id_ready = 1'b1;
    hold_reset();
    exp_req = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h44, 32'h48, 32'h4C};
    exp_out = '{32'h00, 32'h04, 32'h40, 32'h44};
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    cyc();
    check("t3_redir_noreq", 32'(s_req), 32'd0);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    cyc();
    check("t3_flushed", 32'(s_valid), 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    drained("t3");

    // Misaligned redirect concurrent with a pop of head 0x10
    id_ready = 1'b1;
    hold_reset();
    exp_req = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20, 32'h24, 32'h28, 32'h2C};
    exp_out = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h20, 32'h24};
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h23;
    cyc();
    check("t4_redir_noreq", 32'(s_req), 32'd0);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    drained("t4");

    // Asynchronous reset in mid-stream, then restart from RESET_PC
    id_ready = 1'b1;
    hold_reset();
    exp_req = '{32'h00, 32'h04, 32'h08};
    exp_out = '{32'h00};
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    #2;
    check("t6_pre_valid", 32'(if_valid), 32'd1);
    check("t6_pre_req", 32'(imem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("t6_async_valid", 32'(if_valid), 32'd0);
    check("t6_async_req", 32'(imem_req), 32'd0);
    check("t6_async_pc", if_pc, 32'h0);
    check("t6_async_addr", imem_addr, 32'h0);
    drained("t6a");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_req = '{32'h00, 32'h04, 32'h08, 32'h0C};
    exp_out = '{32'h00, 32'h04};
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i < 2) check("t6_no_stale", 32'(s_valid), 32'd0);
    end
    drained("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
